add72_seq: RTL and testbench
============================

ADD72_SEQ -- requirements
Module: add72_seq

Interface
REQ-001 Parameters: none; operand width fixed at 72 bits, split into two 36-bit halves.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand set A/B/Cin valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 A  input  72  operand A.
REQ-007 B  input  72  operand B.
REQ-008 Cin  input  1  carry-in.
REQ-009 out_valid  output  1  S/Cout hold a completed result.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 S  output  72  registered sum.
REQ-012 Cout  output  1  registered carry-out of bit 71.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The block SHALL implement states IDLE, LO, HI, DONE; in_ready = (state == IDLE), out_valid = (state == DONE), both decoded from state register.
REQ-015 IDLE: on in_valid && in_ready at a rising edge, SHALL capture A, B, Cin into internal registers (carry register <= Cin) and go to LO; otherwise stay in IDLE.
REQ-016 LO: SHALL add A_r[35:0] + B_r[35:0] + carry_r, write S[35:0] and carry_r, go to HI.
REQ-017 HI: SHALL add A_r[71:36] + B_r[71:36] + carry_r, write S[71:36] and Cout, go to DONE.
REQ-018 DONE: S and Cout SHALL be stable; on out_ready go to IDLE, else hold DONE indefinitely.
REQ-019 Result SHALL satisfy {Cout, S} = A + B + Cin, modulo 2^73, for all operand values.
REQ-020 Latency: out_valid SHALL rise exactly 2 rising edges after the accepting edge; minimum issue interval 4 cycles (no overlap of operations).
REQ-021 Input pins SHALL be ignored outside the accepting edge; changing A/B/Cin mid-operation SHALL NOT affect the result.
REQ-022 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE (no queuing).
REQ-023 S and Cout SHALL change only in LO/HI (or reset); after DONE->IDLE they retain the last result.
REQ-024 Carry between halves SHALL pass only through the carry register, never combinationally from low to high half.

Reset
REQ-025 rst_n low at a rising edge SHALL force state IDLE, S = 0, Cout = 0, carry and operand registers = 0, regardless of current state.
REQ-026 After reset: in_ready = 1, out_valid = 0, busy = 0; an operation interrupted by reset SHALL be discarded with no out_valid pulse.
REQ-027 in_valid asserted during the reset cycle SHALL NOT be accepted.

Structure
REQ-028 Shared package add72_pkg SHALL hold the state typedef (IDLE=0, LO=1, HI=2, DONE=3) and constants HALF_W = 36, FULL_W = 72.
REQ-029 Exactly one rca_36b instance SHALL perform both half-additions, its A/B inputs muxed by state and its Cin driven by the carry register.
REQ-030 No other sub-modules; all registers in add72_seq.

Verification
REQ-031 Cross-half carry: A = 72'h000000000FFFFFFFFF, B = 1, Cin = 0 -> S = 72'h000000001000000000, Cout = 0, out_valid 2 edges after accept.
REQ-032 Full carry: A = all ones, B = 0, Cin = 1 -> S = 0, Cout = 1; then A = B = 72'h800000000000000000, Cin = 0 -> S = 0, Cout = 1.
REQ-033 Backpressure: out_ready = 0 for 5 cycles in DONE with second in_valid pulse -> out_valid, S, Cout held, in_ready = 0, second set not accepted; out_ready = 1 -> IDLE next edge.
REQ-034 Reset in HI: rst_n low one cycle -> next cycle state IDLE, out_valid = 0, S = 0, Cout = 0, in_ready = 1.
REQ-035 Random: 1000 back-to-back operations with random A, B, Cin and random out_ready stalls -> every result matches A + B + Cin in 73 bits; A/B toggled mid-operation have no effect.

Source files
------------

// File: rtl/add72_pkg.sv
// rtl/add72_pkg.sv - shared state encoding, widths and half-select helper for add72_seq
package add72_pkg;

    localparam int HALF_W = 36;
    localparam int FULL_W = 72;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Picks the operand half the shared adder works on in a given state.
    function automatic logic [HALF_W-1:0] half_sel(input logic [FULL_W-1:0] v, input state_t st);
        half_sel = (st == HI) ? v[FULL_W-1:HALF_W] : v[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/add72_seq_if.sv
// rtl/add72_seq_if.sv - operand/result handshake bundle for add72_seq
interface add72_seq_if;
    import add72_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [FULL_W-1:0] A;
    logic [FULL_W-1:0] B;
    logic              Cin;
    logic              out_valid;
    logic              out_ready;
    logic [FULL_W-1:0] S;
    logic              Cout;
    logic              busy;

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, S, Cout, busy
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, S, Cout, busy
    );

endinterface

// File: rtl/rca_36b.sv
// rtl/rca_36b.sv - 36-bit combinational adder shared by both halves of add72_seq
module rca_36b
    import add72_pkg::*;
(
    input  logic [HALF_W-1:0] i_a,
    input  logic [HALF_W-1:0] i_b,
    input  logic              i_cin,
    output logic [HALF_W-1:0] o_sum,
    output logic              o_cout
);

    logic [HALF_W:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{HALF_W{1'b0}}, i_cin};
    assign o_sum   = w_total[HALF_W-1:0];
    assign o_cout  = w_total[HALF_W];

endmodule

// File: rtl/add72_seq.sv
// rtl/add72_seq.sv - 72-bit adder computed as two 36-bit halves over two cycles on one adder
module add72_seq
    import add72_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    add72_seq_if.slave  bus
);

    state_t            r_state;
    logic [FULL_W-1:0] r_a;
    logic [FULL_W-1:0] r_b;
    logic              r_carry;
    logic [FULL_W-1:0] r_s;
    logic              r_cout;

    logic [HALF_W-1:0] w_op_a;
    logic [HALF_W-1:0] w_op_b;
    logic [HALF_W-1:0] w_sum;
    logic              w_cout;

    // The low-half carry reaches the high half only via r_carry.
    assign w_op_a = half_sel(r_a, r_state);
    assign w_op_b = half_sel(r_b, r_state);

    rca_36b u_rca (
        .i_a    (w_op_a),
        .i_b    (w_op_b),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_carry <= bus.Cin;
                        r_state <= LO;
                    end
                end
                LO: begin
                    r_s[HALF_W-1:0] <= w_sum;
                    r_carry         <= w_cout;
                    r_state         <= HI;
                end
                HI: begin
                    r_s[FULL_W-1:HALF_W] <= w_sum;
                    r_cout               <= w_cout;
                    r_state              <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.S         = r_s;
    assign bus.Cout      = r_cout;

endmodule

// File: tb/tb_add72_seq.sv
// tb/tb_add72_seq.sv - directed and randomised checks of add72_seq results, latency, backpressure and reset
module tb_add72_seq;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    add72_seq_if bus ();

    add72_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] rnd72();
        return {$urandom(), $urandom(), 8'($urandom())};
    endfunction

    // One operation from IDLE; inputs are scrambled after the accepting edge.
    task automatic run_op(input string tag, input logic [71:0] a, input logic [71:0] b,
                          input logic cin, input logic [72:0] exp, input int stall);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.Cin = cin;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.A = rnd72();
        bus.B = rnd72();
        bus.Cin = 1'($urandom());
        chk({tag, ".ov_e1"}, 73'(bus.out_valid), 73'd0);
        @(negedge clk);
        bus.A = ~bus.A;
        chk({tag, ".ov_e2"}, 73'(bus.out_valid), 73'd0);
        @(negedge clk);
        chk({tag, ".ov_done"}, 73'(bus.out_valid), 73'd1);
        chk({tag, ".sum"}, {bus.Cout, bus.S}, exp);
        for (int i = 0; i < stall; i++) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ".ir_back"}, 73'(bus.in_ready), 73'd1);
    endtask

    initial begin
        logic [71:0] ra;
        logic [71:0] rb;
        logic        rc;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.A = '1;
        bus.B = '1;
        bus.Cin = 1'b1;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy_inval", 73'(bus.busy), 73'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 73'(bus.in_ready), 73'd1);
        chk("rst_out_valid", 73'(bus.out_valid), 73'd0);
        chk("rst_busy", 73'(bus.busy), 73'd0);
        chk("rst_sum", {bus.Cout, bus.S}, 73'd0);

        run_op("xhalf", 72'h000000000FFFFFFFFF, 72'd1, 1'b0, {1'b0, 72'h000000001000000000}, 0);
        run_op("allones", {72{1'b1}}, 72'd0, 1'b1, {1'b1, 72'd0}, 1);
        run_op("msb", 72'h800000000000000000, 72'h800000000000000000, 1'b0, {1'b1, 72'd0}, 0);
        run_op("mixed", 72'h123456789ABCDEF012, 72'h111111111111111111, 1'b1,
               {1'b0, 72'h23456789ABCDF00124}, 2);
        run_op("cinonly", 72'd0, 72'd0, 1'b1, 73'd1, 0);
        chk("retain", {bus.Cout, bus.S}, 73'd1);

        // Backpressure with a second operand set offered while held in DONE.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A = 72'd5;
        bus.B = 72'd7;
        bus.Cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i == 2);
            bus.A = 72'hFF;
            bus.out_ready = 1'b0;
            chk("bp_ov", 73'(bus.out_valid), 73'd1);
            chk("bp_ir", 73'(bus.in_ready), 73'd0);
            chk("bp_sum", {bus.Cout, bus.S}, 73'd12);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("bp_hold_end", 73'(bus.out_valid), 73'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_idle", 73'(bus.in_ready), 73'd1);
        chk("bp_ov_low", 73'(bus.out_valid), 73'd0);
        @(negedge clk);
        chk("bp_not_queued", 73'(bus.busy), 73'd0);
        chk("bp_retain", {bus.Cout, bus.S}, 73'd12);

        // Reset while the high half is being computed.
        bus.in_valid = 1'b1;
        bus.A = {72{1'b1}};
        bus.B = {72{1'b1}};
        bus.Cin = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("hi_busy", 73'(bus.busy), 73'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("hirst_ir", 73'(bus.in_ready), 73'd1);
        chk("hirst_ov", 73'(bus.out_valid), 73'd0);
        chk("hirst_sum", {bus.Cout, bus.S}, 73'd0);
        repeat (3) @(negedge clk);
        chk("hirst_discard", 73'(bus.out_valid), 73'd0);

        for (int k = 0; k < 1000; k++) begin
            ra = rnd72();
            rb = rnd72();
            rc = 1'($urandom());
            if (k % 7 == 0) ra = {72{1'b1}};
            run_op("rand", ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {72'd0, rc}, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
